if_id_hazard_ctrl: RTL
======================

Name: if_id_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Decides each cycle whether the IF/ID register captures a new instruction, holds, or is flushed.
- Decides whether ID/EX receives the decoded instruction or a bubble, and generates ALU operand forwarding selects.
- Keeps a shadow scoreboard of in-flight destination registers: EX, MEM and WB slots.
- Freezes the whole pipeline while data memory is not ready.

Parameters:
- MEM_WAIT_MAX, 16: cycles in MEM_WAIT before mem_timeout is raised.
- CNT_W, 16: width of the saturating stall_count.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  7  Instruction_code[6:0] from IF/ID.
- id_rs1  in  5  source register 1 from IF/ID.
- id_rs2  in  5  source register 2 from IF/ID.
- id_rd  in  5  destination register from IF/ID.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_ready  in  1  data memory completes its access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID clears to NOP at the next edge.
- id_ex_bubble  out  1  ID/EX loads a NOP instead of the ID instruction.
- fwd_a  out  2  rs1 operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  rs2 operand select, same encoding as fwd_a.
- mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_WAIT_MAX.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Decode of id_opcode:
  - Writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - Uses rs1: all opcodes except 0110111, 0010111, 1101111.
  - Uses rs2: 0110011, 0100011, 1100011.
  - Memory access: 0000011 (load), 0100011 (store).
  - rd=x0 never registers as a write and never matches.
- Shadow slots EX, MEM, WB each hold {valid, rd, wr, is_load, is_mem}.
  - Advance on each edge unless frozen: WB<=MEM, MEM<=EX, EX<=ID entry, or empty when a bubble or flush is issued.
  - id_valid=0 enters an empty slot.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when the MEM slot is valid with is_mem=1 and mem_ready=0.
  - MEM_WAIT -> RUN on the cycle mem_ready=1.
- In MEM_WAIT with mem_ready=0 (frozen):
  - pc_en=0, if_id_en=0, flush=0, bubble=0.
  - Shadow slots hold.
- The freeze condition is also evaluated combinationally in RUN, so the first wait cycle freezes with no extra cycle.
- Priority when not frozen:
  - Branch flush: ex_branch_taken=1 gives if_id_flush=1, id_ex_bubble=1, pc_en=1, if_id_en=1, EX<=empty.
  - Load-use: EX slot is_load=1 and its rd equals a used rs1/rs2 of a valid ID instruction. Gives pc_en=0, if_id_en=0, id_ex_bubble=1, EX<=empty. Exactly one bubble per load-use; the dependency is then covered by MEM/WB forwarding.
  - Otherwise: pc_en=1, if_id_en=1, flush=0, bubble=0.
- Simultaneous events:
  - Branch and load-use in the same cycle: flush wins, no stall.
  - Freeze and branch in the same cycle: freeze wins. ex_branch_taken is held by EX and acted on at unfreeze.
- Forwarding is combinational from ID rs vs shadow slots:
  - MEM slot wr=1 with matching rd (and not a pending load in EX) gives 10.
  - Else WB slot wr=1 with matching rd gives 01.
  - Else 00.
  - MEM wins when both MEM and WB match.
- mem_timeout:
  - A wait counter counts cycles in MEM_WAIT and clears on exit.
  - When the counter reaches MEM_WAIT_MAX, mem_timeout sets. It stays set until reset.
- stall_count increments on every cycle with pc_en=0 and saturates at all-ones.
- While reset is high:
  - Shadow slots empty, state RUN, counters 0, mem_timeout=0.
  - pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, fwd_a=fwd_b=00.
- Reset asserted mid-MEM_WAIT aborts the wait immediately. The first cycle after deassert is RUN with pc_en=1.

Test Plan:
- Reset: assert reset for 3 cycles, then release with mem_ready=1 -> first cycle pc_en=1, if_id_en=1, stall_count=0, fwd=00.
- Load-use: lw x5 in EX, then add x6,x5,x7 in ID -> one cycle with pc_en=0 and bubble=1. Next cycle fwd_a=01, stall_count=1.
- Forward priority: addi x3 in MEM, addi x3 in WB, ID sub x4,x3,x3 -> fwd_a=10, fwd_b=10. With ID rs1=x0 -> fwd_a=00.
- Branch over load-use: ex_branch_taken=1 while the load-use condition holds -> if_id_flush=1, bubble=1, pc_en=1, stall_count unchanged.
- Memory wait: sw in MEM with mem_ready=0 for 4 cycles -> pc_en=0 for 4 cycles, shadow holds, stall_count=4. Resume on mem_ready=1.
- Timeout/reset: mem_ready=0 for 20 cycles with MEM_WAIT_MAX=16 -> mem_timeout=1 from cycle 16. Reset mid-wait -> clears; RUN after release.

Source files
------------

// File: rtl/if_id_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: IF/ID hold/flush,
// ID/EX bubbles, operand forwarding selects and a freeze while data memory is busy.
module if_id_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic       is_mem;
  } slot_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  slot_t             ex_q, mem_q, wb_q;
  slot_t             id_entry;
  logic              dec_wr, dec_rs1, dec_rs2, dec_load, dec_mem;
  logic              frozen, load_use;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  // ---------------- instruction decode ----------------
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    dec_wr   = 1'b0;
    dec_rs1  = 1'b0;
    dec_rs2  = 1'b0;
    dec_load = 1'b0;
    dec_mem  = 1'b0;
    case (id_opcode)
      OP_REG:    begin dec_wr = 1'b1; dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
      OP_IMM:    begin dec_wr = 1'b1; dec_rs1 = 1'b1; end
      OP_LOAD:   begin dec_wr = 1'b1; dec_rs1 = 1'b1; dec_load = 1'b1; dec_mem = 1'b1; end
      OP_STORE:  begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; dec_mem = 1'b1; end
      OP_BRANCH: begin dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: dec_wr = 1'b1;
      OP_JALR:   begin dec_wr = 1'b1; dec_rs1 = 1'b1; end
      default:   dec_rs1 = 1'b1;
    endcase
  end

  always_comb begin
    id_entry = '0;
    if (id_valid) begin
      id_entry.valid   = 1'b1;
      id_entry.rd      = id_rd;
      id_entry.wr      = dec_wr && (id_rd != 5'd0);
      id_entry.is_load = dec_load;
      id_entry.is_mem  = dec_mem;
    end
  end

  // ---------------- hazard detection ----------------
  // The first wait cycle is caught from the MEM slot itself, before the FSM has moved.
  assign frozen = !mem_ready && ((state_q == MEM_WAIT) || (mem_q.valid && mem_q.is_mem));

  // ex_q.wr is already clear for rd=x0, so a load to x0 never stalls.
  assign load_use = id_valid && ex_q.valid && ex_q.is_load && ex_q.wr &&
                    ((dec_rs1 && (id_rs1 == ex_q.rd)) || (dec_rs2 && (id_rs2 == ex_q.rd)));

  // A load sitting in MEM has no result in EX/MEM yet; its data arrives through MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input slot_t m, input slot_t w);
    if (rs == 5'd0)
      return FWD_RF;
    else if (m.valid && m.wr && (m.rd == rs))
      return m.is_load ? FWD_WB : FWD_MEM;
    else if (w.valid && w.wr && (w.rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    fwd_a        = fwd_sel(id_rs1, mem_q, wb_q);
    fwd_b        = fwd_sel(id_rs2, mem_q, wb_q);
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end else if (frozen) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // ---------------- memory-wait FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_q.valid && mem_q.is_mem && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  assign wait_nxt = (wait_cnt == WAIT_W'(MEM_WAIT_MAX)) ? wait_cnt : wait_cnt + WAIT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;

      if (!frozen) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= id_ex_bubble ? slot_t'('0) : id_entry;
      end

      if (state_d == MEM_WAIT) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == WAIT_W'(MEM_WAIT_MAX)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (!pc_en && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
